// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the write-back register file.
// Imported by wb_regfile and wb_scoreboard.
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int REG_NUM    = 32;

    localparam logic [ADDR_W_DEF-1:0] REG_ZERO  = 5'd0;
    localparam logic [DATA_W_DEF-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic                  ENABLE    = 1'b1;
    localparam logic                  DISABLE   = 1'b0;

    // Write-back source select: load data or ALU result.
    function automatic logic [DATA_W_DEF-1:0] wb_select(
        input logic                  memtoreg,
        input logic [DATA_W_DEF-1:0] mmdata,
        input logic [DATA_W_DEF-1:0] result
    );
        return memtoreg ? mmdata : result;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one busy bit per GPR, r0 never busy.
// Ports: clk/rst, set (load issue), clr (effective write), two raw lookups.
module wb_scoreboard
    import wb_regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_i,
    input  logic [ADDR_W-1:0] set_idx_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] clr_idx_i,
    input  logic [ADDR_W-1:0] a_idx_i,
    input  logic [ADDR_W-1:0] b_idx_i,
    output logic              a_busy_o,
    output logic              b_busy_o
);

    localparam int N = 1 << ADDR_W;

    logic [N-1:0] busy_q;
    logic [N-1:0] busy_d;

    // Clear is applied first so a same-cycle set (younger load) wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_idx_i] = DISABLE;
        end
        if (set_i) begin
            busy_d[set_idx_i] = ENABLE;
        end
        busy_d[0] = DISABLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign a_busy_o = busy_q[a_idx_i];
    assign b_busy_o = busy_q[b_idx_i];

endmodule

// File: rtl/wb_regfile.sv
// MEM/WB consumer: write-back mux, 32x32 GPR file with two bypassed read
// ports, pending-load scoreboard lookups and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wb_mmdata,
    input  logic [DATA_W-1:0] wb_result,
    input  logic [ADDR_W-1:0] wb_regdst,
    input  logic              wb_memtoreg,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              ld_issue,
    input  logic [ADDR_W-1:0] ld_dst,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [31:0]       wb_commit_cnt
);

    localparam int  N      = 1 << ADDR_W;
    localparam bit  BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] regs_q [N];
    logic [31:0]       cnt_q;
    logic [31:0]       cnt_d;
    logic              eff_wr;
    logic              byp_rs;
    logic              byp_rt;
    logic              sb_rs;
    logic              sb_rt;

    assign wb_wdata = wb_memtoreg ? wb_mmdata : wb_result;

    // rst folded in so bypass and busy clearing are inert during reset.
    assign eff_wr = rst && wb_regwrite && (wb_regdst != '0);

    assign byp_rs = BYP_EN && eff_wr && (wb_regdst == rs_addr);
    assign byp_rt = BYP_EN && eff_wr && (wb_regdst == rt_addr);

    always_comb begin
        rs_data = regs_q[rs_addr];
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (byp_rs) begin
            rs_data = wb_wdata;
        end
    end

    always_comb begin
        rt_data = regs_q[rt_addr];
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (byp_rt) begin
            rt_data = wb_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                regs_q[i] <= '0;
            end
        end else if (eff_wr) begin
            regs_q[wb_regdst] <= wb_wdata;
        end
    end

    assign cnt_d = eff_wr ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wb_commit_cnt = cnt_q;

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_i     (ld_issue),
        .set_idx_i (ld_dst),
        .clr_i     (eff_wr),
        .clr_idx_i (wb_regdst),
        .a_idx_i   (rs_addr),
        .b_idx_i   (rt_addr),
        .a_busy_o  (sb_rs),
        .b_busy_o  (sb_rt)
    );

    // A load that is retiring this cycle no longer blocks its readers.
    assign rs_busy = rst && sb_rs && !byp_rs;
    assign rt_busy = rst && sb_rt && !byp_rt;

endmodule
